// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage: PC, IF/ID register, stall/redirect,
//            boot cycle and halt on the all-zero instruction.
//            Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
  output logic        halted,
  output logic        fetch_fault
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic [1:0]  r_state, w_next_state;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_if_valid, w_if_valid_nxt;
  logic [31:0] r_if_pc, w_if_pc_nxt;
  logic [31:0] r_if_pc4, w_if_pc4_nxt;
  logic [31:0] r_if_inst, w_if_inst_nxt;
  logic [31:0] w_redirect_target;
  logic        w_misaligned;
  logic        w_inst_zero;

`ifdef FETCH_MISALIGN_TRAP_EN
  // Full target kept so a faulting address is visible for debug.
  assign w_redirect_target = redirect_pc;
  assign w_misaligned      = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign w_redirect_target = redirect_pc & ~32'h0000_0003;
  assign w_misaligned      = 1'b0;
`endif

  assign w_inst_zero = (imem_data == 32'h0000_0000);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_BOOT;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_BOOT: w_next_state = w_misaligned ? S_FAULT : S_RUN;
      S_RUN: begin
        if (redirect_valid)   w_next_state = w_misaligned ? S_FAULT : S_RUN;
        else if (stall)       w_next_state = S_RUN;
        else if (w_inst_zero) w_next_state = S_HALT;
        else                  w_next_state = S_RUN;
      end
      S_HALT: begin
        if (redirect_valid) w_next_state = w_misaligned ? S_FAULT : S_RUN;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_FAULT: w_next_state = S_FAULT;
`else
      S_FAULT: w_next_state = S_BOOT;
`endif
      default: w_next_state = S_BOOT;
    endcase
  end

  // Datapath next values: PC and IF/ID register
  always_comb begin
    w_pc_nxt       = r_pc;
    w_if_valid_nxt = r_if_valid;
    w_if_pc_nxt    = r_if_pc;
    w_if_pc4_nxt   = r_if_pc4;
    w_if_inst_nxt  = r_if_inst;
    case (r_state)
      S_BOOT, S_HALT: begin
        w_if_valid_nxt = 1'b0;
        if (redirect_valid) w_pc_nxt = w_redirect_target;
      end
      S_RUN: begin
        if (redirect_valid) begin
          w_pc_nxt       = w_redirect_target;
          w_if_valid_nxt = 1'b0;
        end else if (stall) begin
          w_pc_nxt = r_pc;
        end else if (w_inst_zero) begin
          w_if_valid_nxt = 1'b0;
        end else begin
          w_if_inst_nxt  = imem_data;
          w_if_pc_nxt    = r_pc;
          w_if_pc4_nxt   = r_pc + PC_STEP;
          w_if_valid_nxt = 1'b1;
          w_pc_nxt       = r_pc + PC_STEP;
        end
      end
      default: w_if_valid_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_pc4   <= 32'h0;
      r_if_inst  <= C_NOP;
    end else begin
      r_pc       <= w_pc_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_pc4   <= w_if_pc4_nxt;
      r_if_inst  <= w_if_inst_nxt;
    end
  end

  // Output logic
  always_comb begin
    imem_addr = r_pc;
    if_valid  = r_if_valid;
    if_pc     = r_if_pc;
    if_pc4    = r_if_pc4;
    if_inst   = r_if_inst;
    halted    = (r_state == S_HALT);
`ifdef FETCH_MISALIGN_TRAP_EN
    fetch_fault = (r_state == S_FAULT);
`else
    fetch_fault = 1'b0;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit with a small
//            combinational instruction memory.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;
  logic        halted;
  logic        fetch_fault;

  logic [31:0] mem [0:63];
  int          n_checks;
  int          n_errors;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (32'd4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_pc4        (if_pc4),
    .if_inst       (if_inst),
    .halted        (halted),
    .fetch_fault   (fetch_fault)
  );

  assign imem_data = mem[imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h0100_0413;
    mem[1]  = 32'h1010_0493;
    mem[2]  = 32'h0084_8933;
    mem[3]  = 32'h0000_0000;
    mem[8]  = 32'h0050_0093;
    mem[63] = 32'h00A0_0113;

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1;
    check("rst_if_valid", {31'b0, if_valid}, 32'h0);
    check("rst_if_pc",    if_pc,   32'h0);
    check("rst_if_pc4",   if_pc4,  32'h0);
    check("rst_if_inst",  if_inst, 32'h0000_0013);
    check("rst_addr",     imem_addr, 32'h0);
    check("rst_halted",   {31'b0, halted}, 32'h0);
    check("rst_fault",    {31'b0, fetch_fault}, 32'h0);

    // Free run from reset
    step(); step();
    rst = 1'b0;
    step();
    check("boot_valid", {31'b0, if_valid}, 32'h0);
    check("boot_addr",  imem_addr, 32'h0);
    step();
    check("f0_inst", if_inst, 32'h0100_0413);
    check("f0_pc",   if_pc,   32'h0);
    check("f0_pc4",  if_pc4,  32'h4);
    check("f0_valid", {31'b0, if_valid}, 32'h1);
    step();
    check("f1_inst", if_inst, 32'h1010_0493);
    check("f1_pc",   if_pc,   32'h4);
    check("f1_pc4",  if_pc4,  32'h8);
    step();
    check("f2_inst", if_inst, 32'h0084_8933);
    check("f2_pc",   if_pc,   32'h8);
    check("f2_pc4",  if_pc4,  32'hC);
    step();
    check("halt_flag",  {31'b0, halted},   32'h1);
    check("halt_valid", {31'b0, if_valid}, 32'h0);
    check("halt_addr",  imem_addr, 32'hC);
    stall = 1'b1;
    step();
    stall = 1'b0;
    check("halt_hold",  {31'b0, halted}, 32'h1);
    check("halt_addr2", imem_addr, 32'hC);

    // Leave HALT via redirect to 0
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    check("unhalt_flag",  {31'b0, halted},   32'h0);
    check("unhalt_valid", {31'b0, if_valid}, 32'h0);
    check("unhalt_addr",  imem_addr, 32'h0);
    step();
    check("resume_inst", if_inst, 32'h0100_0413);
    check("resume_pc",   if_pc,   32'h0);

    // Stall three cycles at pc = 4
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", imem_addr, 32'h4);
      check("stall_pc",   if_pc,     32'h0);
      check("stall_inst", if_inst,   32'h0100_0413);
    end
    stall = 1'b0;
    step();
    check("unstall_pc",   if_pc,   32'h4);
    check("unstall_inst", if_inst, 32'h1010_0493);
    check("unstall_addr", imem_addr, 32'h8);

    // Redirect with stall at pc = 8
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    stall = 1'b0; redirect_valid = 1'b0;
    check("redir_addr",  imem_addr, 32'h20);
    check("redir_valid", {31'b0, if_valid}, 32'h0);
    check("redir_ifpc",  if_pc, 32'h4);
    step();
    check("redir_pc",    if_pc,   32'h20);
    check("redir_pc4",   if_pc4,  32'h24);
    check("redir_inst",  if_inst, 32'h0050_0093);
    check("redir_v1",    {31'b0, if_valid}, 32'h1);

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_ifpc", if_pc,    32'hFFFF_FFFC);
    check("wrap_pc4",  if_pc4,   32'h0);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_inst", if_inst,  32'h00A0_0113);

    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'b0, if_valid}, 32'h0);
    check("arst_pc",    if_pc,    32'h0);
    check("arst_pc4",   if_pc4,   32'h0);
    check("arst_inst",  if_inst,  32'h0000_0013);
    check("arst_addr",  imem_addr, 32'h0);
    step();
    rst = 1'b0;
    step();

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    step();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_addr",  imem_addr, 32'h22);
    check("mis_fault", {31'b0, fetch_fault}, 32'h1);
`else
    check("mis_addr",  imem_addr, 32'h20);
    check("mis_fault", {31'b0, fetch_fault}, 32'h0);
`endif
    check("mis_valid", {31'b0, if_valid}, 32'h0);
    redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    check("fault_frozen", imem_addr, 32'h22);
    check("fault_sticky", {31'b0, fetch_fault}, 32'h1);
`else
    check("mis_redir2", imem_addr, 32'h40);
    check("mis_nofault", {31'b0, fetch_fault}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
